tetron_collision_checker: RTL and testbench
===========================================

# tetron_collision_checker

Consumes the four block offsets produced by a tetron shaper, adds them to the piece anchor, and reads the board occupancy memory one cell at a time. It reports whether the placed piece would overlap an occupied cell or leave the playfield. It sits between the shaper outputs and the game controller, which uses the result to accept or reject a move, rotation or drop.

## Interface
Parameters:
- BOARD_W, 10, playfield columns.
- BOARD_H, 20, playfield rows.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- start  in  1  request a check. Accepted only while busy=0.
- anchor_row  in  5  piece anchor row, unsigned.
- anchor_col  in  5  piece anchor column, unsigned.
- blk1_voffset .. blk4_voffset  in  5 each  shaper row offsets, unsigned.
- blk1_hoffset .. blk4_hoffset  in  5 each  shaper column offsets, unsigned.
- board_rd_en  out  1  board read strobe.
- board_rd_row  out  5  read row address.
- board_rd_col  out  5  read column address.
- board_rd_data  in  1  occupancy of the addressed cell. Valid exactly one cycle after board_rd_en.
- busy  out  1  check in progress.
- done  out  1  one-cycle completion pulse.
- collide  out  1  result. Valid from done; held until the next accepted start.
- collide_mask  out  4  per-block result; bit k-1 corresponds to block k.

## Operation
- States: IDLE, RD, CHK, DONE. Block index k runs from 1 to 4.
- Accepting start:
  - start with busy=0 (in IDLE or DONE) latches the anchor and all 8 offsets.
  - It clears collide and collide_mask, sets k=1 and enters RD.
  - start with busy=1 is ignored; latched operands never change mid-check.
- Cell address: row = anchor_row + voffset, col = anchor_col + hoffset. Both sums are 6-bit and unsigned.
- Bounds: a block is out of bounds (OOB) if row ≥ BOARD_H or col ≥ BOARD_W.
- RD state:
  - If block k is in bounds: board_rd_en=1 and the address bits [4:0] are driven.
  - If block k is OOB: board_rd_en stays 0.
  - Always proceeds to CHK.
- CHK state:
  - Block k hits if it is OOB or board_rd_data=1.
  - A hit sets collide_mask[k-1] and collide.
  - If k<4, k increments and the FSM goes to RD; otherwise it goes to DONE.
- DONE state: done=1 and busy=0 for one cycle, then IDLE. A start arriving in DONE is accepted normally.
- busy=1 in RD and CHK only.
- board_rd_row and board_rd_col may hold any value when board_rd_en=0.

## Timing
- Reset values: IDLE state, k=1, busy=0, done=0, collide=0, collide_mask=0, board_rd_en=0, board_rd_row=0, board_rd_col=0.
- Asserting rst_n mid-check aborts the check immediately. done is never issued for the aborted request.
- Cycle numbering: start is sampled at cycle 0.
  - Block k: RD at cycle 2k-1, CHK at cycle 2k.
  - DONE at cycle 9, so full-check latency is 9 cycles.
- Timing is fixed: OOB blocks still consume their RD and CHK cycles.
- At most one outstanding read. board_rd_en is never high in two consecutive cycles.

## Configuration
- Macro: COLLIDE_EARLY_EXIT_EN.
- Defined: a hit in CHK for block k goes straight to DONE. Latency becomes 2k+1. collide_mask has exactly one bit set (the first hit), and no reads are issued for later blocks.
- Undefined: all four blocks are always checked, latency is always 9, and collide_mask is complete.

## Structure
- Shared package tetris_pkg holds:
  - BOARD_W and BOARD_H defaults.
  - The 5-bit offset/coordinate typedef.
  - The FSM state enum.
- One sub-module, tetron_cell_addr: combinational 6-bit adder plus bounds compare, producing {row, col, oob}. Instantiated once and muxed by k.

## Test plan
- Empty board, anchor (0,0), O offsets (0,0),(1,1),(0,1),(1,0):
  - Reads occur in that order at cycles 1,3,5,7.
  - done at cycle 9 with collide=0, mask=0000.
- Cell (1,1) occupied, same piece:
  - Without the macro: collide=1, mask=0010, done at cycle 9.
  - With COLLIDE_EARLY_EXIT_EN: done at cycle 5 and only 2 reads are issued.
- Anchor (19,8), O piece:
  - Blocks 2 and 4 (row 20) are OOB.
  - No board_rd_en at cycles 3 and 7.
  - Without the macro: mask=1010, collide=1.
- start re-pulsed at cycles 2–6 with different operands:
  - Ignored; addresses still come from the original operands; a single done at cycle 9.
- rst_n low at cycle 4:
  - All outputs return to their reset values asynchronously; no done is issued.
  - A new start after reset completes normally at 9 cycles.
- start asserted in the DONE cycle:
  - Accepted; the first read follows one cycle later.

Source files
------------

// File: rtl/tetris_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : tetris_pkg                                               |
// | Description : Shared playfield defaults, coordinate type and collision |
// |               checker FSM state encoding.                              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package tetris_pkg;

   localparam int unsigned BOARD_W_DEFAULT = 10;
   localparam int unsigned BOARD_H_DEFAULT = 20;

   // 5-bit unsigned offset / coordinate
   typedef logic [4:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_CHK  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/tetron_cell_addr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tetron_cell_addr                                         |
// | Description : Combinational cell address generator. Adds one block     |
// |               offset to the piece anchor with a 6-bit unsigned sum and |
// |               flags the cell as out of bounds when it leaves the board.|
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   anchor_row, anchor_col  in  5  piece anchor                          |
// |   voffset, hoffset        in  5  block offsets                         |
// |   row, col                out 5  low bits of the cell address          |
// |   oob                     out 1  cell lies outside the playfield       |
// +------------------------------------------------------------------------+
module tetron_cell_addr
   import tetris_pkg::*;
#(
   parameter int unsigned BOARD_W = BOARD_W_DEFAULT,
   parameter int unsigned BOARD_H = BOARD_H_DEFAULT
) (
   input  logic [4:0] anchor_row,
   input  logic [4:0] anchor_col,
   input  logic [4:0] voffset,
   input  logic [4:0] hoffset,
   output logic [4:0] row,
   output logic [4:0] col,
   output logic       oob
);

   localparam logic [5:0] ROW_LIM = 6'(BOARD_H);
   localparam logic [5:0] COL_LIM = 6'(BOARD_W);

   logic [5:0] sum_row;
   logic [5:0] sum_col;

   // Keep the carry so 16+16 is seen as 32 (off the board) rather than
   // wrapping back to 0.
   assign sum_row = {1'b0, anchor_row} + {1'b0, voffset};
   assign sum_col = {1'b0, anchor_col} + {1'b0, hoffset};

   assign oob = (sum_row >= ROW_LIM) || (sum_col >= COL_LIM);

   // Bit 5 is always zero for an in-bounds cell, so only the low bits
   // are useful as a read address; bit 5 is already folded into oob.
   assign row = sum_row[4:0];
   assign col = sum_col[4:0];

endmodule : tetron_cell_addr
`default_nettype wire

// File: rtl/tetron_collision_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tetron_collision_checker                                 |
// | Description : Checks the four blocks of a placed tetron against the    |
// |               board occupancy memory, one read per block, and reports  |
// |               overlap or playfield exit per block and overall.         |
// | Revision    : 1.0 - initial release                                    |
// | Build option: COLLIDE_EARLY_EXIT_EN - stop at the first hitting block. |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   clk, rst_n                  clock, async active-low reset            |
// |   start                  in   request a check (taken when busy=0)      |
// |   anchor_row/anchor_col  in 5 piece anchor                             |
// |   blkN_voffset/hoffset   in 5 shaper offsets, N = 1..4                 |
// |   board_rd_en/row/col    out  board read strobe and address           |
// |   board_rd_data          in   occupancy, one cycle after board_rd_en   |
// |   busy, done             out  status / one-cycle completion pulse     |
// |   collide, collide_mask  out  overall and per-block result            |
// +------------------------------------------------------------------------+
module tetron_collision_checker
   import tetris_pkg::*;
#(
   parameter int unsigned BOARD_W = BOARD_W_DEFAULT,
   parameter int unsigned BOARD_H = BOARD_H_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] anchor_row,
   input  logic [4:0] anchor_col,
   input  logic [4:0] blk1_voffset,
   input  logic [4:0] blk2_voffset,
   input  logic [4:0] blk3_voffset,
   input  logic [4:0] blk4_voffset,
   input  logic [4:0] blk1_hoffset,
   input  logic [4:0] blk2_hoffset,
   input  logic [4:0] blk3_hoffset,
   input  logic [4:0] blk4_hoffset,
   output logic       board_rd_en,
   output logic [4:0] board_rd_row,
   output logic [4:0] board_rd_col,
   input  logic       board_rd_data,
   output logic       busy,
   output logic       done,
   output logic       collide,
   output logic [3:0] collide_mask
);

   state_e     state_q, state_d;
   logic [1:0] blk_q, blk_d;            // current block index k-1
   coord_t     anchor_row_q, anchor_row_d;
   coord_t     anchor_col_q, anchor_col_d;
   coord_t     voff_q [4];
   coord_t     voff_d [4];
   coord_t     hoff_q [4];
   coord_t     hoff_d [4];
   logic       collide_q, collide_d;
   logic [3:0] mask_q, mask_d;

   coord_t     cell_row;
   coord_t     cell_col;
   logic       cell_oob;
   logic       blk_hit;

   // One address unit shared by all four blocks; the latched offsets of
   // the current block are selected by k.
   tetron_cell_addr #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H)
   ) u_cell_addr (
      .anchor_row (anchor_row_q),
      .anchor_col (anchor_col_q),
      .voffset    (voff_q[blk_q]),
      .hoffset    (hoff_q[blk_q]),
      .row        (cell_row),
      .col        (cell_col),
      .oob        (cell_oob)
   );

   // An OOB block never issued a read, so the data input is irrelevant.
   assign blk_hit = cell_oob | board_rd_data;

   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      anchor_row_d = anchor_row_q;
      anchor_col_d = anchor_col_q;
      voff_d       = voff_q;
      hoff_d       = hoff_q;
      collide_d    = collide_q;
      mask_d       = mask_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               anchor_row_d = anchor_row;
               anchor_col_d = anchor_col;
               voff_d[0]    = blk1_voffset;
               voff_d[1]    = blk2_voffset;
               voff_d[2]    = blk3_voffset;
               voff_d[3]    = blk4_voffset;
               hoff_d[0]    = blk1_hoffset;
               hoff_d[1]    = blk2_hoffset;
               hoff_d[2]    = blk3_hoffset;
               hoff_d[3]    = blk4_hoffset;
               collide_d    = 1'b0;
               mask_d       = 4'b0000;
               blk_d        = 2'd0;
               state_d      = ST_RD;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end

         ST_RD: begin
            state_d = ST_CHK;
         end

         ST_CHK: begin
            if (blk_hit) begin
               mask_d[blk_q] = 1'b1;
               collide_d     = 1'b1;
            end
`ifdef COLLIDE_EARLY_EXIT_EN
            if (blk_hit || (blk_q == 2'd3)) begin
               state_d = ST_DONE;
            end else begin
               blk_d   = blk_q + 2'd1;
               state_d = ST_RD;
            end
`else
            if (blk_q == 2'd3) begin
               state_d = ST_DONE;
            end else begin
               blk_d   = blk_q + 2'd1;
               state_d = ST_RD;
            end
`endif
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         blk_q        <= 2'd0;
         anchor_row_q <= '0;
         anchor_col_q <= '0;
         for (int i = 0; i < 4; i++) begin
            voff_q[i] <= '0;
            hoff_q[i] <= '0;
         end
         collide_q    <= 1'b0;
         mask_q       <= 4'b0000;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         anchor_row_q <= anchor_row_d;
         anchor_col_q <= anchor_col_d;
         voff_q       <= voff_d;
         hoff_q       <= hoff_d;
         collide_q    <= collide_d;
         mask_q       <= mask_d;
      end
   end

   // RD and CHK alternate, so the strobe can never be high two cycles
   // running. The address is zeroed when idle so reset values hold.
   assign board_rd_en  = (state_q == ST_RD) && !cell_oob;
   assign board_rd_row = board_rd_en ? cell_row : 5'd0;
   assign board_rd_col = board_rd_en ? cell_col : 5'd0;

   assign busy         = (state_q == ST_RD) || (state_q == ST_CHK);
   assign done         = (state_q == ST_DONE);
   assign collide      = collide_q;
   assign collide_mask = mask_q;

endmodule : tetron_collision_checker
`default_nettype wire

// File: tb/tb_tetron_collision_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_tetron_collision_checker                              |
// | Description : Self-checking bench: directed table, multi-cycle corner  |
// |               sequences and random pieces against a board model.      |
// |               Honours COLLIDE_EARLY_EXIT_EN when defined.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_tetron_collision_checker;

   localparam int BW = 10;
   localparam int BH = 20;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [4:0] drv_ar, drv_ac;
   logic [4:0] drv_v [4];
   logic [4:0] drv_h [4];
   logic       board_rd_en;
   logic [4:0] board_rd_row, board_rd_col;
   logic       board_rd_data;
   logic       busy, done, collide;
   logic [3:0] collide_mask;

   tetron_collision_checker #(.BOARD_W(BW), .BOARD_H(BH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .anchor_row    (drv_ar),
      .anchor_col    (drv_ac),
      .blk1_voffset  (drv_v[0]),
      .blk2_voffset  (drv_v[1]),
      .blk3_voffset  (drv_v[2]),
      .blk4_voffset  (drv_v[3]),
      .blk1_hoffset  (drv_h[0]),
      .blk2_hoffset  (drv_h[1]),
      .blk3_hoffset  (drv_h[2]),
      .blk4_hoffset  (drv_h[3]),
      .board_rd_en   (board_rd_en),
      .board_rd_row  (board_rd_row),
      .board_rd_col  (board_rd_col),
      .board_rd_data (board_rd_data),
      .busy          (busy),
      .done          (done),
      .collide       (collide),
      .collide_mask  (collide_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board occupancy model
   bit occ [0:BH-1][0:BW-1];

   always @(posedge clk) begin
      if (board_rd_en) begin
         if (int'(board_rd_row) < BH && int'(board_rd_col) < BW)
            board_rd_data <= occ[board_rd_row][board_rd_col];
         else
            board_rd_data <= 1'b1;
      end else begin
         board_rd_data <= 1'($urandom_range(0, 1));
      end
   end

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Operands of the request under test
   logic [4:0] cur_ar, cur_ac;
   logic [4:0] cur_v [4];
   logic [4:0] cur_h [4];

   // Reference model results
   logic [3:0] m_mask;
   int         m_lat;
   bit         m_oob [4];
   int         m_r [4];
   int         m_c [4];

   task automatic model_eval();
      bit stop;
      bit hit;
      stop   = 0;
      m_mask = 4'b0000;
      m_lat  = 9;
      for (int k = 0; k < 4; k++) begin
         m_r[k]   = int'(cur_ar) + int'(cur_v[k]);
         m_c[k]   = int'(cur_ac) + int'(cur_h[k]);
         m_oob[k] = (m_r[k] >= BH) || (m_c[k] >= BW);
         if (!stop) begin
            hit = m_oob[k] ? 1'b1 : occ[m_r[k]][m_c[k]];
            if (hit) begin
               m_mask[k] = 1'b1;
`ifdef COLLIDE_EARLY_EXIT_EN
               stop  = 1;
               m_lat = 2 * k + 3;
`endif
            end
         end
      end
   endtask

   task automatic set_board(input int sel);
      for (int r = 0; r < BH; r++)
         for (int c = 0; c < BW; c++)
            case (sel)
               1:       occ[r][c] = (r == 1 && c == 1);
               2:       occ[r][c] = 1'b1;
               3:       occ[r][c] = ($urandom_range(0, 3) == 0);
               default: occ[r][c] = 1'b0;
            endcase
   endtask

   task automatic apply_start();
      drv_ar = cur_ar;
      drv_ac = cur_ac;
      for (int k = 0; k < 4; k++) begin
         drv_v[k] = cur_v[k];
         drv_h[k] = cur_h[k];
      end
      start = 1'b1;
   endtask

   typedef struct packed {
      logic [4:0]      ar;
      logic [4:0]      ac;
      logic [3:0][4:0] v;
      logic [3:0][4:0] h;
      int              board;
      logic [3:0]      mask;
      int              lat;
   } vec_t;

   localparam int NTBL = 7;
   vec_t tbl [NTBL];

   function automatic vec_t mk(input int ar, input int ac,
                               input int v1, input int v2, input int v3, input int v4,
                               input int h1, input int h2, input int h3, input int h4,
                               input int board, input logic [3:0] mask, input int lat);
      vec_t t;
      t.ar = 5'(ar);  t.ac = 5'(ac);
      t.v[0] = 5'(v1); t.v[1] = 5'(v2); t.v[2] = 5'(v3); t.v[3] = 5'(v4);
      t.h[0] = 5'(h1); t.h[1] = 5'(h2); t.h[2] = 5'(h3); t.h[3] = 5'(h4);
      t.board = board; t.mask = mask; t.lat = lat;
      return t;
   endfunction

   task automatic load_vec(input int i);
      cur_ar = tbl[i].ar;
      cur_ac = tbl[i].ac;
      for (int k = 0; k < 4; k++) begin
         cur_v[k] = tbl[i].v[k];
         cur_h[k] = tbl[i].h[k];
      end
      set_board(tbl[i].board);
   endtask

   // Called at the cycle in which start is presented (cycle 0, just after
   // an edge). Follows the request to its done cycle.
   task automatic run_check(input string tag, input logic [3:0] emask, input int elat,
                            input bit repulse, input bit chain, input int nxt);
      bit exp_en;
      int k;
      model_eval();
      @(posedge clk); #1;
      for (int c = 1; c <= elat; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         start = 1'b0;
         if (repulse && c >= 2 && c <= 6 && c < elat) begin
            drv_ar = 5'($urandom);
            drv_ac = 5'($urandom);
            for (int j = 0; j < 4; j++) begin
               drv_v[j] = 5'($urandom);
               drv_h[j] = 5'($urandom);
            end
            start = 1'b1;
         end
         k = (c - 1) / 2;
         if (c < elat) begin
            chk($sformatf("%s c%0d busy", tag, c), busy, 1);
            chk($sformatf("%s c%0d done", tag, c), done, 0);
            exp_en = (c % 2 == 1) && !m_oob[k];
            chk($sformatf("%s c%0d rd_en", tag, c), board_rd_en, exp_en);
            if (exp_en) begin
               chk($sformatf("%s c%0d rd_row", tag, c), board_rd_row, m_r[k]);
               chk($sformatf("%s c%0d rd_col", tag, c), board_rd_col, m_c[k]);
            end
         end else begin
            chk($sformatf("%s done", tag), done, 1);
            chk($sformatf("%s busy@done", tag), busy, 0);
            chk($sformatf("%s rd_en@done", tag), board_rd_en, 0);
            chk($sformatf("%s collide", tag), collide, (emask != 0));
            chk($sformatf("%s mask", tag), collide_mask, emask);
         end
      end
      if (chain) begin
         load_vec(nxt);
         apply_start();
      end else begin
         @(posedge clk); #1;
         chk($sformatf("%s done after", tag), done, 0);
         chk($sformatf("%s busy after", tag), busy, 0);
         chk($sformatf("%s collide held", tag), collide, (emask != 0));
         chk($sformatf("%s mask held", tag), collide_mask, emask);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " busy"},    busy, 0);
      chk({tag, " done"},    done, 0);
      chk({tag, " collide"}, collide, 0);
      chk({tag, " mask"},    collide_mask, 0);
      chk({tag, " rd_en"},   board_rd_en, 0);
      chk({tag, " rd_row"},  board_rd_row, 0);
      chk({tag, " rd_col"},  board_rd_col, 0);
   endtask

   initial begin
      // Board 0 empty, 1 cell (1,1), 2 full
`ifdef COLLIDE_EARLY_EXIT_EN
      tbl[0] = mk(0, 0,  0, 1, 0, 1,  0, 1, 1, 0,  0, 4'b0000, 9);
      tbl[1] = mk(0, 0,  0, 1, 0, 1,  0, 1, 1, 0,  1, 4'b0010, 5);
      tbl[2] = mk(19, 8, 0, 1, 0, 1,  0, 1, 1, 0,  0, 4'b0010, 5);
      tbl[3] = mk(16, 0, 0, 16, 0, 0, 0, 0, 1, 2,  0, 4'b0010, 5);
      tbl[4] = mk(0, 8,  0, 0, 0, 0,  0, 1, 24, 2, 0, 4'b0100, 7);
      tbl[5] = mk(5, 5,  0, 0, 0, 0,  0, 0, 0, 0,  2, 4'b0001, 3);
      tbl[6] = mk(1, 1,  0, 0, 0, 0,  1, 2, 3, 0,  1, 4'b1000, 9);
`else
      tbl[0] = mk(0, 0,  0, 1, 0, 1,  0, 1, 1, 0,  0, 4'b0000, 9);
      tbl[1] = mk(0, 0,  0, 1, 0, 1,  0, 1, 1, 0,  1, 4'b0010, 9);
      tbl[2] = mk(19, 8, 0, 1, 0, 1,  0, 1, 1, 0,  0, 4'b1010, 9);
      tbl[3] = mk(16, 0, 0, 16, 0, 0, 0, 0, 1, 2,  0, 4'b0010, 9);
      tbl[4] = mk(0, 8,  0, 0, 0, 0,  0, 1, 24, 2, 0, 4'b1100, 9);
      tbl[5] = mk(5, 5,  0, 0, 0, 0,  0, 0, 0, 0,  2, 4'b1111, 9);
      tbl[6] = mk(1, 1,  0, 0, 0, 0,  1, 2, 3, 0,  1, 4'b1000, 9);
`endif

      rst_n  = 1'b0;
      start  = 1'b0;
      drv_ar = '0;
      drv_ac = '0;
      for (int k = 0; k < 4; k++) begin
         drv_v[k] = '0;
         drv_h[k] = '0;
      end
      set_board(0);
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < NTBL; i++) begin
         load_vec(i);
         apply_start();
         run_check($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].lat, 1'b0, 1'b0, 0);
      end

      // start presented during the DONE cycle
      load_vec(0);
      apply_start();
      run_check("chainA", tbl[0].mask, tbl[0].lat, 1'b0, 1'b1, 1);
      run_check("chainB", tbl[1].mask, tbl[1].lat, 1'b0, 1'b0, 0);

      // start re-pulsed mid-check with unrelated operands
      load_vec(0);
      apply_start();
      run_check("repulse", tbl[0].mask, tbl[0].lat, 1'b1, 1'b0, 0);

      // Reset in the middle of a check
      load_vec(0);
      apply_start();
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst no done c%0d", c), done, 0);
         chk($sformatf("midrst idle c%0d", c), busy, 0);
      end
      load_vec(1);
      apply_start();
      run_check("postrst", tbl[1].mask, tbl[1].lat, 1'b0, 1'b0, 0);

      // Random pieces on random boards
      for (int n = 0; n < 40; n++) begin
         cur_ar = 5'($urandom_range(0, 21));
         cur_ac = 5'($urandom_range(0, 11));
         for (int k = 0; k < 4; k++) begin
            cur_v[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            cur_h[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         end
         set_board(3);
         model_eval();
         apply_start();
         run_check($sformatf("rnd%0d", n), m_mask, m_lat, 1'b0, 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_tetron_collision_checker
`default_nettype wire
